// File: rtl/sched_mac_filtros_if.sv
// Handshake bundle between sample strobe source, MAC scheduler and datapath.
// master drives strobe/enables; slave (scheduler) drives datapath controls.
interface sched_mac_filtros_if #(
   parameter int N_CANALES = 3,
   parameter int CANAL_W   = 2
);
   logic                 cambiar;
   logic [N_CANALES-1:0] canal_en;
   logic [CANAL_W-1:0]   canal;
   logic [3:0]           sel;
   logic                 rst_acum;
   logic                 leer;
   logic                 desp;
   logic                 leer_y;
   logic                 ocupado;
   logic                 listo;
   logic                 overrun;

   modport master (
      output cambiar, canal_en,
      input  canal, sel, rst_acum, leer, desp, leer_y,
      input  ocupado, listo, overrun
   );

   modport slave (
      input  cambiar, canal_en,
      output canal, sel, rst_acum, leer, desp, leer_y,
      output ocupado, listo, overrun
   );
endinterface

// File: rtl/sched_mac_filtros.sv
// Shares one MAC between N_CANALES IIR channels, ascending index order.
// Optional SCHED_PENDIENTE_EN: queue one strobe that arrives while busy.
module sched_mac_filtros #(
   parameter int N_CANALES = 3,
   parameter int N_PASOS   = 5,
   parameter int CANAL_W   = 2
) (
   input logic                clk,
   input logic                rst,
   sched_mac_filtros_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, LIMPIAR, MAC, ESCRIBIR, DESPLAZAR, SALIDA, FIN
   } estado_t;

   estado_t              estado_q, estado_d;
   logic [N_CANALES-1:0] mask_q, mask_d;
   logic [CANAL_W-1:0]   canal_q, canal_d;
   logic [3:0]           sel_q, sel_d;
   logic                 ovr_q, ovr_d;
   logic                 rst_acum_q, leer_q, desp_q, leer_y_q;
   logic                 ocupado_q, listo_q;
   logic                 arranque;
`ifdef SCHED_PENDIENTE_EN
   logic                 pend_q, pend_d;
`endif

   function automatic logic [CANAL_W-1:0] primer(
      input logic [N_CANALES-1:0] m
   );
      primer = '0;
      for (int i = N_CANALES - 1; i >= 0; i--)
         if (m[i]) primer = CANAL_W'(i);
   endfunction

   always_comb begin
      estado_d = estado_q;
      mask_d   = mask_q;
      canal_d  = canal_q;
      sel_d    = '0;
      ovr_d    = ovr_q;
      arranque = 1'b0;
`ifdef SCHED_PENDIENTE_EN
      pend_d   = pend_q;
`endif
      if (bus.cambiar && estado_q != IDLE) begin
`ifdef SCHED_PENDIENTE_EN
         if (pend_q) ovr_d = 1'b1;
         else        pend_d = 1'b1;
`else
         ovr_d = 1'b1;
`endif
      end
      unique case (estado_q)
         IDLE: begin
`ifdef SCHED_PENDIENTE_EN
            arranque = bus.cambiar | pend_q;
            pend_d   = 1'b0;
`else
            arranque = bus.cambiar;
`endif
         end
         LIMPIAR: estado_d = MAC;
         MAC: begin
            if (sel_q == 4'(N_PASOS - 1)) estado_d = ESCRIBIR;
            else sel_d = sel_q + 4'd1;
         end
         ESCRIBIR:  estado_d = DESPLAZAR;
         DESPLAZAR: estado_d = SALIDA;
         SALIDA: begin
            for (int i = 0; i < N_CANALES; i++)
               if (CANAL_W'(i) == canal_q) mask_d[i] = 1'b0;
            if (|mask_d) begin
               estado_d = LIMPIAR;
               canal_d  = primer(mask_d);
            end else begin
               estado_d = FIN;
            end
         end
         FIN: begin
            estado_d = IDLE;
`ifdef SCHED_PENDIENTE_EN
            if (pend_q) begin
               arranque = 1'b1;
               pend_d   = 1'b0;
            end
`endif
         end
         default: estado_d = IDLE;
      endcase
      // an empty mask still walks through FIN so listo pulses
      if (arranque) begin
         mask_d = bus.canal_en;
         if (|bus.canal_en) begin
            estado_d = LIMPIAR;
            canal_d  = primer(bus.canal_en);
         end else begin
            estado_d = FIN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q   <= IDLE;
         mask_q     <= '0;
         canal_q    <= '0;
         sel_q      <= '0;
         ovr_q      <= 1'b0;
         rst_acum_q <= 1'b1;
         leer_q     <= 1'b0;
         desp_q     <= 1'b0;
         leer_y_q   <= 1'b0;
         ocupado_q  <= 1'b0;
         listo_q    <= 1'b0;
`ifdef SCHED_PENDIENTE_EN
         pend_q     <= 1'b0;
`endif
      end else begin
         estado_q   <= estado_d;
         mask_q     <= mask_d;
         canal_q    <= canal_d;
         sel_q      <= sel_d;
         ovr_q      <= ovr_d;
         rst_acum_q <= (estado_d == IDLE) || (estado_d == LIMPIAR);
         leer_q     <= (estado_d == ESCRIBIR);
         desp_q     <= (estado_d == DESPLAZAR);
         leer_y_q   <= (estado_d == SALIDA);
         ocupado_q  <= (estado_d != IDLE);
         listo_q    <= (estado_d == FIN);
`ifdef SCHED_PENDIENTE_EN
         pend_q     <= pend_d;
`endif
      end
   end

   assign bus.canal    = canal_q;
   assign bus.sel      = sel_q;
   assign bus.rst_acum = rst_acum_q;
   assign bus.leer     = leer_q;
   assign bus.desp     = desp_q;
   assign bus.leer_y   = leer_y_q;
   assign bus.ocupado  = ocupado_q;
   assign bus.listo    = listo_q;
   assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_sched_mac_filtros.sv
// Scoreboard bench: a cycle-stamped queue of expected control vectors
// is built from the channel mask; a negedge monitor compares each cycle.
module tb_sched_mac_filtros;
   localparam int NC  = 3;
   localparam int NP  = 5;
   localparam int CW  = 2;
   localparam int INF = 32'h7fffffff;

   logic clk = 1'b0;
   logic rst;

   sched_mac_filtros_if #(.N_CANALES(NC), .CANAL_W(CW)) bus();

   sched_mac_filtros #(
      .N_CANALES(NC), .N_PASOS(NP), .CANAL_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [CW-1:0] canal;
      logic [3:0]  sel;
      logic        rst_acum, leer, desp, leer_y, listo;
   } exp_t;

   exp_t q[$];
   int   cyc        = 0;
   int   busy_end   = -1;
   int   ovr_from   = INF;
   int   last_canal = 0;
   bit   pend       = 1'b0;
   int   n_chk      = 0;
   int   n_err      = 0;

   function automatic void push(int c, int ch, int s,
                                bit ra, bit le, bit de, bit ly, bit li);
      exp_t e;
      e.cyc = c; e.canal = CW'(ch); e.sel = 4'(s);
      e.rst_acum = ra; e.leer = le; e.desp = de;
      e.leer_y = ly; e.listo = li;
      q.push_back(e);
   endfunction

   // one sample pass: every enabled channel gets clear, NP MACs,
   // write, shift, output load; then a single listo cycle
   function automatic void launch(logic [NC-1:0] en, int t);
      int n;
      n = t + 1;
      for (int ch = 0; ch < NC; ch++) begin
         if (en[ch]) begin
            push(n, ch, 0, 1, 0, 0, 0, 0); n++;
            for (int s = 0; s < NP; s++) begin
               push(n, ch, s, 0, 0, 0, 0, 0); n++;
            end
            push(n, ch, 0, 0, 1, 0, 0, 0); n++;
            push(n, ch, 0, 0, 0, 1, 0, 0); n++;
            push(n, ch, 0, 0, 0, 0, 1, 0); n++;
            last_canal = ch;
         end
      end
      push(n, last_canal, 0, 0, 0, 0, 0, 1);
      busy_end = n;
   endfunction

   function automatic void mark_ovr(int t);
      if (ovr_from > t + 1) ovr_from = t + 1;
   endfunction

   function automatic void model(bit c, logic [NC-1:0] en, int t);
      bit busy;
      busy = (t <= busy_end);
`ifdef SCHED_PENDIENTE_EN
      if (busy) begin
         if (t == busy_end && pend) begin
            if (c) mark_ovr(t);
            pend = 1'b0;
            launch(en, t);
         end else if (c) begin
            if (pend) mark_ovr(t);
            else      pend = 1'b1;
         end
      end else if (c || pend) begin
         pend = 1'b0;
         launch(en, t);
      end
`else
      if (c) begin
         if (busy) mark_ovr(t);
         else      launch(en, t);
      end
`endif
   endfunction

   task automatic step(input bit c, input logic [NC-1:0] en, input bit r);
      @(posedge clk);
      cyc++;
      #1;
      if (r) c = 1'b0;
      bus.cambiar  = c;
      bus.canal_en = en;
      rst          = r;
      if (r) begin
         q.delete();
         busy_end   = -1;
         ovr_from   = INF;
         pend       = 1'b0;
         last_canal = 0;
      end else begin
         model(c, en, cyc);
      end
   endtask

   task automatic idle(input int n, input logic [NC-1:0] en);
      for (int i = 0; i < n; i++) step(1'b0, en, 1'b0);
   endtask

   initial begin
      logic [CW-1:0] idle_canal;
      logic [12:0]   got, expv;
      exp_t          e;
      idle_canal = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            idle_canal = '0;
         end else begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
               e = q.pop_front();
               expv = {1'b1, e.canal, e.sel, e.rst_acum, e.leer,
                       e.desp, e.leer_y, e.listo, 1'b0};
               idle_canal = e.canal;
            end else begin
               expv = {1'b0, idle_canal, 4'd0, 1'b1, 5'b0};
            end
            expv[0] = (cyc >= ovr_from);
            got = {bus.ocupado, bus.canal, bus.sel, bus.rst_acum,
                   bus.leer, bus.desp, bus.leer_y, bus.listo,
                   bus.overrun};
            n_chk++;
            if (got !== expv) begin
               n_err++;
               $display("FAIL cyc%0d ctl {ocup,canal,sel,racum,leer,desp,ly,listo,ovr} got=%b exp=%b",
                        cyc, got, expv);
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.cambiar  = 1'b0;
      bus.canal_en = '0;
      step(1'b0, 3'b000, 1'b1);
      step(1'b0, 3'b000, 1'b1);
      idle(3, 3'b000);
      step(1'b1, 3'b101, 1'b0);
      idle(22, 3'b101);
      step(1'b1, 3'b000, 1'b0);
      idle(4, 3'b000);
      step(1'b1, 3'b111, 1'b0);
      idle(9, 3'b111);
      step(1'b1, 3'b111, 1'b0);
      idle(55, 3'b111);
      step(1'b1, 3'b011, 1'b0);
      idle(11, 3'b011);
      step(1'b0, 3'b011, 1'b1);
      idle(2, 3'b011);
      step(1'b1, 3'b011, 1'b0);
      idle(25, 3'b011);
      step(1'b1, 3'b001, 1'b0);
      idle(2, 3'b001);
      idle(12, 3'b111);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 19) == 0, 3'($urandom),
              $urandom_range(0, 299) == 0);
      for (int i = 0; i < 300 && (cyc <= busy_end || pend); i++)
         step(1'b0, 3'b000, 1'b0);
      idle(3, 3'b000);
      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end
endmodule
